// File: rtl/mor1kx_tlb_reload_arbiter_pkg.sv
// Shared grant indices for the TLB reload arbiter.
// Also holds the one-hot grant helper.
package mor1kx_tlb_reload_arbiter_pkg;

    localparam logic GRANT_IMMU = 1'b0;
    localparam logic GRANT_DMMU = 1'b1;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return (idx == GRANT_DMMU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Shares one page-table bus port between the IMMU and DMMU reload walkers.
// Holds the grant for a whole walk; a watchdog turns hung accesses into zero-data acks.
module mor1kx_tlb_reload_arbiter
    import mor1kx_tlb_reload_arbiter_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_TIMEOUT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,
    output logic [1:0]                      grant_o,
    output logic                            timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t                          state;
    logic                            owner;
    logic                            last_grant;
    logic                            pick;
    logic [OPTION_TIMEOUT_WIDTH-1:0] wdog;
    logic                            in_access;
    logic                            wdog_full;
    logic                            done;
    logic                            owner_req;
    logic [OPTION_OPERAND_WIDTH-1:0] owner_addr;
    logic [OPTION_OPERAND_WIDTH-1:0] pick_addr;

    assign in_access  = (state == ST_ACCESS);
    assign wdog_full  = &wdog;
    assign done       = in_access & (bus_ack_i | bus_err_i | wdog_full);
    assign owner_req  = (owner == GRANT_DMMU) ? dmmu_req_i : immu_req_i;
    assign owner_addr = (owner == GRANT_DMMU) ? dmmu_addr_i : immu_addr_i;
    assign pick_addr  = (pick == GRANT_DMMU) ? dmmu_addr_i : immu_addr_i;

    assign bus_req_o  = in_access;
    // A real ack in the saturating cycle wins over the watchdog.
    assign timeout_o  = in_access & wdog_full & ~bus_ack_i;

    assign immu_ack_o  = done & (owner == GRANT_IMMU);
    assign dmmu_ack_o  = done & (owner == GRANT_DMMU);
    assign immu_data_o = (immu_ack_o & bus_ack_i) ? bus_dat_i : '0;
    assign dmmu_data_o = (dmmu_ack_o & bus_ack_i) ? bus_dat_i : '0;

    // Round-robin pick: on a tie the walker not granted last wins.
    always_comb begin
        pick = GRANT_IMMU;
        if (immu_req_i && dmmu_req_i) begin
            pick = (last_grant == GRANT_DMMU) ? GRANT_IMMU : GRANT_DMMU;
        end else if (dmmu_req_i) begin
            pick = GRANT_DMMU;
        end
    end

    // Walk sequencer: grant, access, one-cycle gap, then next access or release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= GRANT_IMMU;
            last_grant <= GRANT_DMMU;
            wdog       <= '0;
            bus_addr_o <= '0;
            grant_o    <= 2'b00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (immu_req_i || dmmu_req_i) begin
                        owner      <= pick;
                        bus_addr_o <= pick_addr;
                        grant_o    <= grant_onehot(pick);
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    wdog <= wdog + 1'b1;
                    if (done) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    wdog <= '0;
                    if (owner_req) begin
                        bus_addr_o <= owner_addr;
                        state      <= ST_ACCESS;
                    end else begin
                        last_grant <= owner;
                        grant_o    <= 2'b00;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Self-checking bench for the TLB reload arbiter.
// Walk timelines are predicted from cycle arithmetic on the arbitration rules.
module tb_mor1kx_tlb_reload_arbiter;

    localparam int W      = 4;
    localparam int TO_CYC = (1 << W) - 1;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_TO   = 3;
    localparam int K_SAT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        immu_req = 1'b0;
    logic [31:0] immu_addr = '0;
    logic        immu_ack_o;
    logic [31:0] immu_data_o;
    logic        dmmu_req = 1'b0;
    logic [31:0] dmmu_addr = '0;
    logic        dmmu_ack_o;
    logic [31:0] dmmu_data_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_dat = '0;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int tests = 0;
    int fails = 0;

    bit          sc_req[2];
    logic [31:0] sc_addr[2][2];
    int          acc_kind[4];
    int          acc_lat[4];
    logic [31:0] acc_dat[4];
    bit          spurious;
    int          mdl_last;

    mor1kx_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_TIMEOUT_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .immu_req_i(immu_req),
        .immu_addr_i(immu_addr),
        .immu_ack_o(immu_ack_o),
        .immu_data_o(immu_data_o),
        .dmmu_req_i(dmmu_req),
        .dmmu_addr_i(dmmu_addr),
        .dmmu_ack_o(dmmu_ack_o),
        .dmmu_data_o(dmmu_data_o),
        .bus_req_o(bus_req_o),
        .bus_addr_o(bus_addr_o),
        .bus_ack_i(bus_ack),
        .bus_err_i(bus_err),
        .bus_dat_i(bus_dat),
        .grant_o(grant_o),
        .timeout_o(timeout_o)
    );

    initial forever #5 clk = ~clk;

    task automatic run_scenario(input string name);
        int          order[2];
        int          nw;
        int          t;
        int          ncyc;
        int          n_acc;
        int          ex_start[4];
        int          ex_end[4];
        int          ex_own[4];
        logic [31:0] ex_addr[4];
        logic [31:0] ex_data[4];
        bit          ex_to[4];
        bit          wreq[2];
        int          wk[2];
        bit          ackseen[2];
        int          acc_idx;
        int          cnt;
        bit          prev_req;
        logic [5:0]  e_ctl;
        logic [5:0]  o_ctl;
        logic [31:0] e_addr;
        logic [63:0] e_dat;
        bit          e_req;
        nw = 0;
        if (sc_req[0] && sc_req[1]) begin
            order[0] = (mdl_last == 1) ? 0 : 1;
            order[1] = 1 - order[0];
            nw = 2;
        end else if (sc_req[0]) begin
            order[0] = 0;
            nw = 1;
        end else if (sc_req[1]) begin
            order[0] = 1;
            nw = 1;
        end
        n_acc = 0;
        t = 1;
        ncyc = 2;
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 2; k++) begin
                ex_start[n_acc] = t;
                ex_own[n_acc]   = order[w];
                ex_addr[n_acc]  = sc_addr[order[w]][k];
                ex_to[n_acc]    = (acc_kind[n_acc] == K_TO);
                ex_end[n_acc]   = t + (ex_to[n_acc] ? TO_CYC : acc_lat[n_acc]);
                if (acc_kind[n_acc] == K_ERR || acc_kind[n_acc] == K_TO)
                    ex_data[n_acc] = '0;
                else
                    ex_data[n_acc] = acc_dat[n_acc];
                t = ex_end[n_acc] + ((k == 0) ? 2 : 3);
                ncyc = ex_end[n_acc] + 2;
                n_acc++;
            end
            mdl_last = order[w];
        end
        wreq[0] = sc_req[0];
        wreq[1] = sc_req[1];
        wk[0] = 0;
        wk[1] = 0;
        ackseen[0] = 0;
        ackseen[1] = 0;
        acc_idx = -1;
        cnt = 0;
        prev_req = 0;
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            for (int w = 0; w < 2; w++) begin
                if (ackseen[w]) begin
                    if (wk[w] == 0) wk[w] = 1;
                    else wreq[w] = 0;
                end
                ackseen[w] = 0;
            end
            immu_req  = wreq[0];
            immu_addr = sc_addr[0][wk[0]];
            dmmu_req  = wreq[1];
            dmmu_addr = sc_addr[1][wk[1]];
            bus_ack = 1'b0;
            bus_err = 1'b0;
            bus_dat = $urandom;
            if (bus_req_o) begin
                if (!prev_req) begin
                    acc_idx++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
                if (acc_idx >= 0 && acc_idx < 4) begin
                    if (acc_kind[acc_idx] != K_TO && cnt == acc_lat[acc_idx]) begin
                        bus_ack = (acc_kind[acc_idx] != K_ERR);
                        bus_err = (acc_kind[acc_idx] == K_ERR) ||
                                  (acc_kind[acc_idx] == K_BOTH);
                        bus_dat = acc_dat[acc_idx];
                    end
                end
            end else if (spurious) begin
                bus_ack = 1'b1;
            end
            prev_req = bus_req_o;
            #1;
            e_ctl = '0;
            e_addr = '0;
            e_dat = '0;
            e_req = 0;
            for (int a = 0; a < n_acc; a++) begin
                if (c >= ex_start[a] && c <= ex_end[a]) begin
                    e_req = 1;
                    e_ctl[5] = 1'b1;
                    e_addr = ex_addr[a];
                end
                if (c >= ex_start[a] && c <= ex_end[a] + 1)
                    e_ctl[4:3] = (ex_own[a] == 1) ? 2'b10 : 2'b01;
                if (c == ex_end[a]) begin
                    if (ex_own[a] == 1) begin
                        e_ctl[1] = 1'b1;
                        e_dat[31:0] = ex_data[a];
                    end else begin
                        e_ctl[2] = 1'b1;
                        e_dat[63:32] = ex_data[a];
                    end
                    e_ctl[0] = ex_to[a];
                end
            end
            o_ctl = {bus_req_o, grant_o, immu_ack_o, dmmu_ack_o, timeout_o};
            tests++;
            if (o_ctl !== e_ctl) begin
                fails++;
                $display("FAIL %s ctl cyc=%0d req/grant/iack/dack/to got=%b exp=%b",
                         name, c, o_ctl, e_ctl);
            end
            tests++;
            if ({immu_data_o, dmmu_data_o} !== e_dat) begin
                fails++;
                $display("FAIL %s data cyc=%0d got=%h exp=%h",
                         name, c, {immu_data_o, dmmu_data_o}, e_dat);
            end
            if (e_req) begin
                tests++;
                if (bus_addr_o !== e_addr) begin
                    fails++;
                    $display("FAIL %s addr cyc=%0d got=%h exp=%h",
                             name, c, bus_addr_o, e_addr);
                end
            end
            ackseen[0] = immu_ack_o;
            ackseen[1] = dmmu_ack_o;
        end
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        bus_err = 1'b0;
        immu_req = 1'b0;
        dmmu_req = 1'b0;
    endtask

    task automatic set_acc(input int i, input int kind, input int lat,
                           input logic [31:0] dat);
        acc_kind[i] = kind;
        acc_lat[i]  = (kind == K_SAT) ? TO_CYC : lat;
        acc_dat[i]  = dat;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        immu_req = 1'b0;
        dmmu_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if ({bus_req_o, grant_o, immu_ack_o, dmmu_ack_o, timeout_o,
             bus_addr_o, immu_data_o, dmmu_data_o} !== '0) begin
            fails++;
            $display("FAIL reset_hold got req=%b grant=%b addr=%h exp all zero",
                     bus_req_o, grant_o, bus_addr_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if ({bus_req_o, grant_o, immu_ack_o, dmmu_ack_o, timeout_o,
             bus_addr_o, immu_data_o, dmmu_data_o} !== '0) begin
            fails++;
            $display("FAIL reset_release got req=%b grant=%b addr=%h exp all zero",
                     bus_req_o, grant_o, bus_addr_o);
        end
        mdl_last = 1;
        spurious = 0;
    endtask

    task automatic test_simultaneous();
        sc_req[0] = 1;
        sc_req[1] = 1;
        sc_addr[0][0] = 32'h0000_1100;
        sc_addr[0][1] = 32'h0040_3004;
        sc_addr[1][0] = 32'h0000_2200;
        sc_addr[1][1] = 32'h0080_1010;
        set_acc(0, K_ACK, 1, 32'h1111_0000);
        set_acc(1, K_ACK, 0, 32'h1111_0001);
        set_acc(2, K_ACK, 2, 32'h2222_0000);
        set_acc(3, K_ACK, 1, 32'h2222_0001);
        run_scenario("simul_pair1");
        sc_req[1] = 0;
        run_scenario("simul_immu_only");
        sc_req[1] = 1;
        run_scenario("simul_pair2");
    endtask

    task automatic test_single_immu();
        sc_req[0] = 1;
        sc_req[1] = 0;
        sc_addr[0][0] = 32'h0000_1000;
        sc_addr[0][1] = 32'h0040_2008;
        set_acc(0, K_ACK, 3, 32'h0040_2000);
        set_acc(1, K_ACK, 2, 32'h0000_0501);
        run_scenario("single_immu");
    endtask

    task automatic test_bus_err();
        sc_req[0] = 0;
        sc_req[1] = 1;
        sc_addr[1][0] = 32'h0000_3300;
        sc_addr[1][1] = 32'h0000_3308;
        set_acc(0, K_ERR, 2, 32'hDEAD_BEEF);
        set_acc(1, K_BOTH, 1, 32'h0000_0777);
        run_scenario("bus_err");
    endtask

    task automatic test_watchdog();
        sc_req[0] = 1;
        sc_req[1] = 0;
        sc_addr[0][0] = 32'h0000_4400;
        sc_addr[0][1] = 32'h0000_4404;
        set_acc(0, K_TO, 0, 32'hCAFE_0000);
        set_acc(1, K_SAT, 0, 32'h0000_0ABC);
        run_scenario("watchdog");
    endtask

    task automatic test_spurious();
        spurious = 1;
        sc_req[0] = 0;
        sc_req[1] = 1;
        sc_addr[1][0] = 32'h0000_5500;
        sc_addr[1][1] = 32'h0000_5508;
        set_acc(0, K_ACK, 1, 32'h5555_AAAA);
        set_acc(1, K_ACK, 3, 32'hAAAA_5555);
        run_scenario("spurious");
        spurious = 0;
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk);
        #1;
        dmmu_req = 1'b1;
        dmmu_addr = 32'h0000_6600;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if ({bus_req_o, grant_o} !== 3'b110) begin
            fails++;
            $display("FAIL midrst_pre req/grant got=%b exp=110",
                     {bus_req_o, grant_o});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmmu_req = 1'b0;
        bus_ack = 1'b1;
        bus_dat = 32'h1234_5678;
        #1;
        tests++;
        if ({bus_req_o, grant_o, immu_ack_o, dmmu_ack_o, timeout_o,
             bus_addr_o, immu_data_o, dmmu_data_o} !== '0) begin
            fails++;
            $display("FAIL midrst_post got req=%b grant=%b dack=%b addr=%h exp all zero",
                     bus_req_o, grant_o, dmmu_ack_o, bus_addr_o);
        end
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        mdl_last = 1;
        sc_req[0] = 1;
        sc_req[1] = 1;
        sc_addr[0][0] = 32'h0000_7700;
        sc_addr[0][1] = 32'h0000_7704;
        sc_addr[1][0] = 32'h0000_8800;
        sc_addr[1][1] = 32'h0000_8804;
        set_acc(0, K_ACK, 0, 32'h7777_0000);
        set_acc(1, K_ACK, 1, 32'h7777_0001);
        set_acc(2, K_ACK, 0, 32'h8888_0000);
        set_acc(3, K_ACK, 2, 32'h8888_0001);
        run_scenario("midrst_pair");
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            sc_req[0] = bit'($urandom_range(0, 1));
            sc_req[1] = bit'($urandom_range(0, 1));
            if (!sc_req[0] && !sc_req[1]) sc_req[r % 2] = 1;
            for (int w = 0; w < 2; w++) begin
                sc_addr[w][0] = $urandom;
                sc_addr[w][1] = $urandom;
            end
            for (int i = 0; i < 4; i++)
                set_acc(i, $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
            spurious = bit'($urandom_range(0, 1));
            run_scenario("random");
        end
        spurious = 0;
    endtask

    initial begin
        spurious = 0;
        mdl_last = 1;
        test_reset();
        test_simultaneous();
        test_single_immu();
        test_bus_err();
        test_watchdog();
        test_spurious();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
